// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences one frame of raster work across a bank of task units.
//   Parameters: UNITS = number of raster task units, OBJ_W = object index/count width.
//   Ports:
//     clk, rst_n            - rising-edge clock, asynchronous active-low reset
//     frame_start           - request a new frame (an overrun if already busy)
//     object_count          - objects in the frame, captured when a frame is accepted
//     unit_enable           - usable units, captured when a frame is accepted
//     obj_req / obj_index   - request the object at obj_index from the object buffer
//     obj_valid             - object buffer has presented the requested object
//     task_start            - one-cycle broadcast start to the units
//     task_done             - per-unit one-cycle completion pulses
//     depth_write_start     - one-cycle pulse starting depth write-back
//     depth_write_complete  - write-back finished
//     buffer_select         - front/back buffer selector, flips once per finished frame
//     busy                  - high whenever not idle
//     frame_done            - one-cycle pulse when the frame is finished
//     frame_overrun         - one-cycle pulse when frame_start arrives while busy
module frame_scheduler #(
    parameter int UNITS = 16,
    parameter int OBJ_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [OBJ_W-1:0] object_count,
    input  logic [UNITS-1:0] unit_enable,
    output logic             obj_req,
    output logic [OBJ_W-1:0] obj_index,
    input  logic             obj_valid,
    output logic             task_start,
    input  logic [UNITS-1:0] task_done,
    output logic             depth_write_start,
    input  logic             depth_write_complete,
    output logic             buffer_select,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_overrun
);
    typedef enum logic [2:0] {IDLE, FETCH, DISPATCH, WAIT_UNITS, NEXT, FLUSH, SWAP} state_t;
    localparam logic [OBJ_W-1:0] ONE = 1;
    state_t state, state_nx;
    logic [OBJ_W-1:0] count_q, idx_nx;
    logic [UNITS-1:0] enable_q, done_mask, mask_nx;
    logic accept;
    assign accept = (state == IDLE) && frame_start;
    always_comb begin
        state_nx = state;
        idx_nx   = obj_index;
        mask_nx  = done_mask;
        case (state)
            IDLE: if (frame_start) begin
                idx_nx   = '0;
                state_nx = (object_count == '0) ? FLUSH : FETCH;
            end
            FETCH: state_nx = obj_valid ? DISPATCH : FETCH;
            DISPATCH: begin
                // disabled units never report, so they start out already done
                mask_nx  = ~enable_q;
                state_nx = WAIT_UNITS;
            end
            WAIT_UNITS: begin
                // a completion arriving this cycle counts toward the exit decision
                mask_nx  = done_mask | task_done;
                state_nx = (&mask_nx) ? NEXT : WAIT_UNITS;
            end
            NEXT: if (obj_index == count_q - ONE) state_nx = FLUSH;
                else begin
                    idx_nx   = obj_index + ONE;
                    state_nx = FETCH;
                end
            FLUSH: state_nx = depth_write_complete ? SWAP : FLUSH;
            SWAP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            obj_index         <= '0;
            done_mask         <= '0;
            count_q           <= '0;
            enable_q          <= '0;
            obj_req           <= 1'b0;
            task_start        <= 1'b0;
            depth_write_start <= 1'b0;
            frame_done        <= 1'b0;
            frame_overrun     <= 1'b0;
            busy              <= 1'b0;
            buffer_select     <= 1'b0;
        end else begin
            state             <= state_nx;
            obj_index         <= idx_nx;
            done_mask         <= mask_nx;
            count_q           <= accept ? object_count : count_q;
            enable_q          <= accept ? unit_enable : enable_q;
            obj_req           <= state_nx == FETCH;
            task_start        <= state_nx == DISPATCH;
            depth_write_start <= (state_nx == FLUSH) && (state != FLUSH);
            frame_done        <= state_nx == SWAP;
            frame_overrun     <= frame_start && (state != IDLE);
            busy              <= state_nx != IDLE;
            buffer_select     <= buffer_select ^ (state_nx == SWAP);
        end
    end
endmodule
